// File: rtl/instruction_fetch_unit.sv
// Fetch-side initiator: owns the PC, issues sequential fetches to a 1-cycle
// synchronous instruction memory and queues {pc, instr} pairs for decode.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               fault
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   fetch_pc_reg;
  logic                inflight_reg;
  logic [ADDR_W-1:0]   inflight_pc_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic                fault_reg;

  logic [ADDR_W-1:0]   ent_pc_reg    [DEPTH];
  logic [INSTR_W-1:0]  ent_instr_reg [DEPTH];

  logic                deq, push, issue, redirect_take, misaligned;
  logic [CNT_W:0]      occupancy;

  assign out_valid = (count_reg != '0) && (state_reg == RUN);
  assign deq       = out_valid & out_ready;

  // Occupancy counts the in-flight word so a returning fetch always has room.
  assign occupancy = {1'b0, count_reg} + (CNT_W+1)'(inflight_reg) - (CNT_W+1)'(deq);

  assign redirect_take = redirect_valid && (state_reg == RUN);
  assign misaligned    = (redirect_pc[1:0] != 2'b00);
  assign issue         = (state_reg == RUN) && !redirect_valid &&
                         (occupancy < (CNT_W+1)'(DEPTH));
  assign push          = inflight_reg && !redirect_take;

  always_comb begin
    state_next = state_reg;
    if (redirect_take && misaligned) state_next = FAULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= RUN;
      fetch_pc_reg    <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      fault_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= issue;
      if (issue) begin
        inflight_pc_reg <= fetch_pc_reg;
        fetch_pc_reg    <= fetch_pc_reg + ADDR_W'(4);
      end
      // Redirect flushes everything, including a same-cycle handshake.
      if (redirect_take) begin
        fetch_pc_reg <= redirect_pc;
        count_reg    <= '0;
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        if (misaligned) fault_reg <= 1'b1;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (deq)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        count_reg <= count_reg + CNT_W'(push) - CNT_W'(deq);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_pc_reg[wr_ptr_reg]    <= inflight_pc_reg;
      ent_instr_reg[wr_ptr_reg] <= imem_instr;
    end
  end

  assign imem_addr = fetch_pc_reg;
  assign fault     = fault_reg;
  assign out_pc    = out_valid ? ent_pc_reg[rd_ptr_reg]    : '0;
  assign out_instr = out_valid ? ent_instr_reg[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: per-cycle vector table plus hand-written reset sequences.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr = '0;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fault;

  int n_checks = 0;
  int n_pass   = 0;

  instruction_fetch_unit #(
    .ADDR_W(64), .INSTR_W(32), .RESET_PC(64'h0), .DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fault(fault)
  );

  always #5 clk = ~clk;

  // Memory word k holds 0x13 + k; one-cycle synchronous read.
  always @(posedge clk) imem_instr <= 32'h13 + {2'b00, imem_addr[31:2]};

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [63:0] rpc;
    logic        ev;
    logic [63:0] epc;
    logic [63:0] eaddr;
    logic        ef;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rdy, logic rv, logic [63:0] rpc,
                              logic ev, logic [63:0] epc, logic [63:0] eaddr, logic ef);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.ef = ef;
    return v;
  endfunction

  function automatic logic [31:0] instr_of(logic [63:0] pc);
    return 32'h13 + {2'b00, pc[31:2]};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_outputs(string tag, logic ev, logic [63:0] epc,
                               logic [63:0] eaddr, logic ef);
    check({tag, " out_valid"}, 64'(out_valid), 64'(ev));
    check({tag, " out_pc"},    out_pc, ev ? epc : 64'h0);
    check({tag, " out_instr"}, 64'(out_instr), ev ? 64'(instr_of(epc)) : 64'h0);
    check({tag, " imem_addr"}, imem_addr, eaddr);
    check({tag, " fault"},     64'(fault), 64'(ef));
  endtask

  initial begin
    // Each row: inputs applied this cycle, then outputs expected at the start of it.
    vecs.push_back(mk(1, 0, 0,      0, 0,      64'h0,   0)); // c0 reset state
    vecs.push_back(mk(1, 0, 0,      0, 0,      64'h4,   0));
    vecs.push_back(mk(1, 0, 0,      1, 64'h0,  64'h8,   0)); // first valid
    vecs.push_back(mk(1, 0, 0,      1, 64'h4,  64'hC,   0));
    vecs.push_back(mk(0, 0, 0,      1, 64'h8,  64'h10,  0)); // backpressure
    vecs.push_back(mk(0, 0, 0,      1, 64'h8,  64'h10,  0));
    vecs.push_back(mk(0, 0, 0,      1, 64'h8,  64'h10,  0));
    vecs.push_back(mk(0, 0, 0,      1, 64'h8,  64'h10,  0));
    vecs.push_back(mk(0, 0, 0,      1, 64'h8,  64'h10,  0));
    vecs.push_back(mk(0, 0, 0,      1, 64'h8,  64'h10,  0));
    vecs.push_back(mk(1, 0, 0,      1, 64'h8,  64'h10,  0)); // release
    vecs.push_back(mk(1, 0, 0,      1, 64'hC,  64'h14,  0));
    vecs.push_back(mk(0, 0, 0,      1, 64'h10, 64'h18,  0)); // fill to 2
    vecs.push_back(mk(0, 1, 64'h40, 1, 64'h10, 64'h18,  0)); // redirect, 2 buffered
    vecs.push_back(mk(1, 0, 0,      0, 0,      64'h40,  0));
    vecs.push_back(mk(1, 0, 0,      0, 0,      64'h44,  0));
    vecs.push_back(mk(1, 0, 0,      1, 64'h40, 64'h48,  0));
    vecs.push_back(mk(1, 0, 0,      1, 64'h44, 64'h4C,  0));
    vecs.push_back(mk(1, 1, 64'h100,1, 64'h48, 64'h50,  0)); // redirect with handshake
    vecs.push_back(mk(1, 0, 0,      0, 0,      64'h100, 0));
    vecs.push_back(mk(1, 0, 0,      0, 0,      64'h104, 0));
    vecs.push_back(mk(1, 0, 0,      1, 64'h100,64'h108, 0));
    vecs.push_back(mk(1, 1, 64'h42, 1, 64'h104,64'h10C, 0)); // misaligned redirect
    vecs.push_back(mk(1, 1, 64'h80, 0, 0,      64'h42,  1)); // ignored in FAULT
    vecs.push_back(mk(1, 0, 0,      0, 0,      64'h42,  1));
    vecs.push_back(mk(1, 0, 0,      0, 0,      64'h42,  1));

    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      check_outputs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].eaddr, vecs[i].ef);
      $display("vec %0d: valid=%b pc=%h instr=%h addr=%h fault=%b | rdy=%b rv=%b rpc=%h",
               i, out_valid, out_pc, out_instr, imem_addr, fault,
               vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      out_ready      = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      @(negedge clk);
    end

    // Async reset out of FAULT clears fault without waiting for a clock edge.
    redirect_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_outputs("rst_from_fault", 0, 0, 64'h0, 0);
    $display("rst from fault: valid=%b addr=%h fault=%b", out_valid, imem_addr, fault);

    // Restart stalled so two entries buffer, then reset mid-cycle.
    @(negedge clk);
    out_ready = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs("stall_full", 1, 64'h0, 64'h8, 0);
    $display("stall full: valid=%b pc=%h addr=%h", out_valid, out_pc, imem_addr);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_outputs("rst_midstream", 0, 0, 64'h0, 0);
    $display("rst midstream: valid=%b pc=%h addr=%h", out_valid, out_pc, imem_addr);

    // Release with decode ready: stream restarts at RESET_PC.
    @(negedge clk);
    out_ready = 1'b1;
    rst_n = 1'b1;
    check_outputs("restart_c0", 0, 0, 64'h0, 0);
    @(negedge clk);
    check_outputs("restart_c1", 0, 0, 64'h4, 0);
    @(negedge clk);
    check_outputs("restart_c2", 1, 64'h0, 64'h8, 0);
    $display("restart c2: valid=%b pc=%h instr=%h", out_valid, out_pc, out_instr);
    @(negedge clk);
    check_outputs("restart_c3", 1, 64'h4, 64'hC, 0);
    $display("restart c3: valid=%b pc=%h instr=%h", out_valid, out_pc, out_instr);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
